hack_cpu_ctrl: RTL and testbench

- Multi-cycle Hack control sequencer that drives the 16-bit ALU. Supplies the ALU's zx/nx/zy/ny/f/no controls and x/y operands, and consumes its out/zr/ng.
- Holds the A, D and PC registers. Accepts one instruction per valid/ready handshake and performs M reads/writes over a simple req/ack memory port.
- Sits between the instruction source and the ALU/data memory. It is the ALU's initiator side.

---
 rtl/hack_cpu_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack control sequencer: holds A/D/PC, drives an external
// combinational ALU and performs M accesses over a req/ack memory port.
module hack_cpu_ctrl #(
  parameter logic [14:0] PC_RESET = 15'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [14:0] pc,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg,
  output logic        instr_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_MREAD,
    S_EXEC,
    S_MWRITE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_instr_q;
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [15:0] r_m;
  logic [15:0] r_res;
  logic [14:0] r_pc;
  logic [14:0] r_addr_q;
  logic [14:0] r_tgt;
  logic        r_jump;
  logic        r_done;

  logic        w_is_c;
  logic        w_a_bit;
  logic        w_dst_a;
  logic        w_dst_d;
  logic        w_dst_m;
  logic [2:0]  w_j;
  logic        w_jump_now;
  logic [14:0] w_pc_inc;

  logic        w_ld_instr;
  logic        w_ld_a_imm;
  logic        w_ld_m;
  logic        w_exec;
  logic        w_retire;
  logic        w_take_jump;
  logic [14:0] w_jump_tgt;

  // Destination field follows the Hack layout: instr[5]=A, instr[4]=D, instr[3]=M.
  assign w_is_c   = r_instr_q[15];
  assign w_a_bit  = r_instr_q[12];
  assign w_dst_a  = r_instr_q[5];
  assign w_dst_d  = r_instr_q[4];
  assign w_dst_m  = r_instr_q[3];
  assign w_j      = r_instr_q[2:0];
  assign w_pc_inc = r_pc + 15'd1;

  assign w_jump_now = (w_j[2] & alu_ng) |
                      (w_j[1] & alu_zr) |
                      (w_j[0] & ~alu_ng & ~alu_zr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ld_instr  = 1'b0;
    w_ld_a_imm  = 1'b0;
    w_ld_m      = 1'b0;
    w_exec      = 1'b0;
    w_retire    = 1'b0;
    w_take_jump = 1'b0;
    w_jump_tgt  = r_a[14:0];
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_ld_instr = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!w_is_c) begin
          w_ld_a_imm = 1'b1;
          w_retire   = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_next = w_a_bit ? S_MREAD : S_EXEC;
        end
      end
      S_MREAD: begin
        if (mem_ack) begin
          w_ld_m = 1'b1;
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec = 1'b1;
        if (w_dst_m) begin
          w_next = S_MWRITE;
        end else begin
          w_retire    = 1'b1;
          w_take_jump = w_jump_now;
          w_next      = S_IDLE;
        end
      end
      S_MWRITE: begin
        // Jump and target were frozen in EXEC, before A could be overwritten.
        w_jump_tgt = r_tgt;
        if (mem_ack) begin
          w_retire    = 1'b1;
          w_take_jump = r_jump;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_q <= '0;
      r_a       <= '0;
      r_d       <= '0;
      r_m       <= '0;
      r_res     <= '0;
      r_pc      <= PC_RESET;
      r_addr_q  <= '0;
      r_tgt     <= '0;
      r_jump    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_retire;
      if (w_ld_instr) begin
        r_instr_q <= instr;
      end
      if (w_ld_a_imm) begin
        r_a <= {1'b0, r_instr_q[14:0]};
      end
      if (w_ld_m) begin
        r_m <= mem_rdata;
      end
      if (w_exec) begin
        r_res    <= alu_out;
        r_addr_q <= r_a[14:0];
        r_tgt    <= r_a[14:0];
        r_jump   <= w_jump_now;
        if (w_dst_d) begin
          r_d <= alu_out;
        end
        if (w_dst_a) begin
          r_a <= alu_out;
        end
      end
      if (w_retire) begin
        r_pc <= w_take_jump ? w_jump_tgt : w_pc_inc;
      end
    end
  end

  assign instr_ready = (r_state == S_IDLE);

  assign alu_x  = r_d;
  assign alu_y  = w_a_bit ? r_m : r_a;
  assign alu_zx = r_instr_q[11];
  assign alu_nx = r_instr_q[10];
  assign alu_zy = r_instr_q[9];
  assign alu_ny = r_instr_q[8];
  assign alu_f  = r_instr_q[7];
  assign alu_no = r_instr_q[6];

  assign mem_req   = (r_state == S_MREAD) || (r_state == S_MWRITE);
  assign mem_we    = (r_state == S_MWRITE);
  assign mem_addr  = (r_state == S_MWRITE) ? r_addr_q : r_a[14:0];
  assign mem_wdata = r_res;

  assign pc         = r_pc;
  assign a_reg      = r_a;
  assign d_reg      = r_d;
  assign instr_done = r_done;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: directed vector table, reset abort
// sequence, then random instructions against an instruction-level model.
module tb_hack_cpu_ctrl;

  localparam logic [14:0] PC_RST = 15'h0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic        alu_zr, alu_ng;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [14:0] pc;
  logic [15:0] a_reg, d_reg;
  logic        instr_done;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .instr_done(instr_done)
  );

  // Hack ALU: c = {zx,nx,zy,ny,f,no}
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0000 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? (xx + yy) : (xx & yy);
    return c[0] ? ~o : o;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  assign alu_zr  = (alu_out == 16'h0000);
  assign alu_ng  = alu_out[15];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] mem [int];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] dflt(input logic [14:0] a);
    return {1'b0, a} ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [14:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [14:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  // Memory responder: acks after ack_delay wait cycles, logs completed writes.
  int          ack_delay = 0;
  bit          spur_en = 1'b0;
  int          stab_err = 0;
  logic [14:0] wq_a [$];
  logic [15:0] wq_d [$];

  initial begin
    int          waitc;
    bit          real_ack;
    bit          in_txn;
    logic [14:0] t_addr;
    logic        t_we;
    logic [15:0] t_wdata;
    waitc = 0; real_ack = 1'b0; in_txn = 1'b0;
    t_addr = '0; t_we = 1'b0; t_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack && real_ack && t_we) begin
        mem[int'(t_addr)] = t_wdata;
        wq_a.push_back(t_addr);
        wq_d.push_back(t_wdata);
      end
      mem_ack  = 1'b0;
      real_ack = 1'b0;
      mem_rdata = 16'($urandom);
      if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1'b1; t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata; waitc = 0;
        end else if (mem_addr !== t_addr || mem_we !== t_we || (t_we && mem_wdata !== t_wdata)) begin
          stab_err++;
        end
        if (waitc >= ack_delay) begin
          mem_ack = 1'b1; real_ack = 1'b1;
          mem_rdata = mem_rd(t_addr);
        end else begin
          waitc++;
        end
      end else begin
        in_txn = 1'b0;
        if (spur_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
      end
    end
  end

  logic        s_req   [64];
  logic        s_we    [64];
  logic [14:0] s_addr  [64];
  logic [15:0] s_wdata [64];
  logic [5:0]  s_ctrl  [64];
  logic [15:0] s_y     [64];
  logic        s_ready [64];

  task automatic record(input int k);
    s_req[k]   = mem_req;
    s_we[k]    = mem_we;
    s_addr[k]  = mem_addr;
    s_wdata[k] = mem_wdata;
    s_ctrl[k]  = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
    s_y[k]     = alu_y;
    s_ready[k] = instr_ready;
  endtask

  // Returns edges from the accept edge (counted as 1) to the edge that raises instr_done.
  task automatic run_instr(input logic [15:0] ins, output int lat);
    int n;
    int k;
    n = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    k = 1;
    record(1);
    while (!instr_done && k < 60) begin
      @(posedge clk); #1; k++;
      record(k);
    end
    lat = k;
    check("done_seen", 32'(instr_done), 32'd1);
    check("ready_at_done", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    check("done_single_pulse", 32'(instr_done), 32'd0);
  endtask

  typedef struct {
    logic [15:0] ins;
    int          dly;
    logic [15:0] ea;
    logic [15:0] ed;
    logic [14:0] epc;
    int          elat;
    int          chk;
  } vec_t;

  vec_t tv [27];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    int wq0;
    logic [15:0] mA, mD, y, out, oldA, rnd;
    logic [14:0] mPC;
    logic [15:0] ins;
    int  dly, elat;
    bit  jmp;

    tv[0]  = '{16'h0005, 0, 16'h0005, 16'h0000, 15'h0001, 2, 0};
    tv[1]  = '{16'h0007, 0, 16'h0007, 16'h0000, 15'h0002, 2, 0};
    tv[2]  = '{16'hEC10, 0, 16'h0007, 16'h0007, 15'h0003, 3, 1};
    tv[3]  = '{16'h0064, 0, 16'h0064, 16'h0007, 15'h0004, 2, 0};
    tv[4]  = '{16'hFC10, 0, 16'h0064, 16'h1234, 15'h0005, 4, 2};
    tv[5]  = '{16'h0007, 0, 16'h0007, 16'h1234, 15'h0006, 2, 0};
    tv[6]  = '{16'hEC10, 0, 16'h0007, 16'h0007, 15'h0007, 3, 0};
    tv[7]  = '{16'h0064, 0, 16'h0064, 16'h0007, 15'h0008, 2, 0};
    tv[8]  = '{16'hE7C8, 3, 16'h0064, 16'h0007, 15'h0009, 7, 3};
    tv[9]  = '{16'hEA90, 0, 16'h0064, 16'h0000, 15'h000A, 3, 0};
    tv[10] = '{16'h0014, 0, 16'h0014, 16'h0000, 15'h000B, 2, 0};
    tv[11] = '{16'hE302, 0, 16'h0014, 16'h0000, 15'h0014, 3, 0};
    tv[12] = '{16'h0005, 0, 16'h0005, 16'h0000, 15'h0015, 2, 0};
    tv[13] = '{16'hEC10, 0, 16'h0005, 16'h0005, 15'h0016, 3, 0};
    tv[14] = '{16'h0014, 0, 16'h0014, 16'h0005, 15'h0017, 2, 0};
    tv[15] = '{16'hE302, 0, 16'h0014, 16'h0005, 15'h0018, 3, 0};
    tv[16] = '{16'hEE90, 0, 16'h0014, 16'hFFFF, 15'h0019, 3, 0};
    tv[17] = '{16'h001E, 0, 16'h001E, 16'hFFFF, 15'h001A, 2, 0};
    tv[18] = '{16'hE304, 0, 16'h001E, 16'hFFFF, 15'h001E, 3, 0};
    tv[19] = '{16'h0028, 0, 16'h0028, 16'hFFFF, 15'h001F, 2, 0};
    tv[20] = '{16'hEA87, 0, 16'h0028, 16'hFFFF, 15'h0028, 3, 0};
    tv[21] = '{16'h0032, 0, 16'h0032, 16'hFFFF, 15'h0029, 2, 0};
    tv[22] = '{16'hEC10, 0, 16'h0032, 16'h0032, 15'h002A, 3, 0};
    tv[23] = '{16'hE7EF, 2, 16'h0033, 16'h0032, 15'h0032, 6, 4};
    tv[24] = '{16'h7FFF, 0, 16'h7FFF, 16'h0032, 15'h0033, 2, 0};
    tv[25] = '{16'hEA87, 0, 16'h7FFF, 16'h0032, 15'h7FFF, 3, 0};
    tv[26] = '{16'h0003, 0, 16'h0003, 16'h0032, 15'h0000, 2, 0};

    mem[100] = 16'h1234;

    #2;
    check("rst_pc", 32'(pc), 32'(PC_RST));
    check("rst_a", 32'(a_reg), 32'h0);
    check("rst_d", 32'(d_reg), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_done", 32'(instr_done), 32'h0);
    check("rst_ready", 32'(instr_ready), 32'h1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      ack_delay = tv[i].dly;
      run_instr(tv[i].ins, lat);
      check($sformatf("a_reg[%0d]", i), 32'(a_reg), 32'(tv[i].ea));
      check($sformatf("d_reg[%0d]", i), 32'(d_reg), 32'(tv[i].ed));
      check($sformatf("pc[%0d]", i), 32'(pc), 32'(tv[i].epc));
      check($sformatf("latency[%0d]", i), 32'(lat), 32'(tv[i].elat));
      check($sformatf("busy_after_accept[%0d]", i), 32'(s_ready[1]), 32'd0);
      case (tv[i].chk)
        1: begin
          check("exec_ctrl", 32'(s_ctrl[2]), 32'b110000);
          check("exec_alu_y", 32'(s_y[2]), 32'h7);
        end
        2: begin
          check("mread_req", 32'({s_req[2], s_we[2]}), 32'b10);
          check("mread_addr", 32'(s_addr[2]), 32'd100);
        end
        3: begin
          cnt = 0;
          for (int k = 1; k <= lat; k++)
            if (s_req[k] && s_we[k] && s_addr[k] == 15'd100 && s_wdata[k] == 16'h0008) cnt++;
          check("mwrite_hold_cycles", 32'(cnt), 32'd4);
          check("mwrite_mem100", 32'(mem_rd(15'd100)), 32'h0008);
        end
        4: check("am_write_old_a", 32'(mem_rd(15'd50)), 32'h0033);
        default: ;
      endcase
    end

    // Abort an M write in flight with an asynchronous reset.
    ack_delay = 50;
    run_instr(16'h003C, lat);
    wq0 = wq_a.size();
    instr = 16'hE7C8;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    cnt = 0;
    while (!(mem_req && mem_we) && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check("abort_write_pending", 32'(mem_req & mem_we), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_pc", 32'(pc), 32'(PC_RST));
    check("abort_a", 32'(a_reg), 32'h0);
    check("abort_d", 32'(d_reg), 32'h0);
    cnt = 0;
    repeat (2) begin
      @(posedge clk); #1; cnt += int'(instr_done);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1; cnt += int'(instr_done);
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    check("abort_no_write", 32'(wq_a.size() - wq0), 32'd0);
    check("abort_mem60", 32'(mem_rd(15'd60)), 32'(dflt(15'd60)));
    check("abort_ready", 32'(instr_ready), 32'd1);

    // Random instructions against an instruction-level model.
    ref_mem = mem;
    mA = 16'h0000; mD = 16'h0000; mPC = PC_RST;
    spur_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rnd = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ins = {11'b0, rnd[4:0]};
        1: ins = {1'b0, rnd[14:0]};
        default: ins = {1'b1, rnd[14:0]};
      endcase
      dly = $urandom_range(0, 3);
      ack_delay = dly;
      if (!ins[15]) begin
        mA = {1'b0, ins[14:0]};
        mPC = mPC + 15'd1;
        elat = 2;
        out = '0; oldA = '0;
      end else begin
        oldA = mA;
        y = ins[12] ? ref_rd(mA[14:0]) : mA;
        out = hack_alu(mD, y, ins[11:6]);
        if (ins[5]) mA = out;
        if (ins[4]) mD = out;
        if (ins[3]) ref_mem[int'(oldA[14:0])] = out;
        jmp = (ins[2] && out[15]) || (ins[1] && out == 16'h0000) ||
              (ins[0] && !out[15] && out != 16'h0000);
        mPC = jmp ? oldA[14:0] : mPC + 15'd1;
        elat = 3 + (ins[12] ? 1 + dly : 0) + (ins[3] ? 1 + dly : 0);
      end
      wq0 = wq_a.size();
      run_instr(ins, lat);
      check($sformatf("rnd_a[%0d] ins=%h", i, ins), 32'(a_reg), 32'(mA));
      check($sformatf("rnd_d[%0d] ins=%h", i, ins), 32'(d_reg), 32'(mD));
      check($sformatf("rnd_pc[%0d] ins=%h", i, ins), 32'(pc), 32'(mPC));
      check($sformatf("rnd_lat[%0d] ins=%h", i, ins), 32'(lat), 32'(elat));
      check($sformatf("rnd_wr_count[%0d]", i), 32'(wq_a.size() - wq0),
            32'((ins[15] && ins[3]) ? 1 : 0));
      if (ins[15] && ins[3] && wq_a.size() > wq0) begin
        check($sformatf("rnd_wr_addr[%0d]", i), 32'(wq_a[wq_a.size() - 1]), 32'(oldA[14:0]));
        check($sformatf("rnd_wr_data[%0d]", i), 32'(wq_d[wq_d.size() - 1]), 32'(out));
      end
    end
    spur_en = 1'b0;

    check("mem_port_stable", 32'(stab_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
